// File: rtl/snax_wide_req_splitter.sv
// -----------------------------------------------------------------------------
// snax_wide_req_splitter
//
// Purpose:
//   Upstream stage of the banked local memory superbank. Takes one wide DMA
//   request and splits it into NumBanks narrow bank requests. Each bank request
//   has its own valid/ready handshake, and banks may complete in any order.
//   For reads, each bank's data arrives one cycle after its own handshake. That
//   data is collected into a buffer and returned as a single wide response.
//   Per-bank stalls are absorbed here, so the wide side only ever sees one
//   transaction.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wide_q_*              wide request (valid/ready, addr, write, data, strb)
//   wide_p_*              wide read response (valid/ready, data)
//   bank_q_*              per-bank requests, flattened with bank 0 in the LSBs
//   bank_p_data_i         per-bank read data, valid the cycle after the handshake
//   busy_o                high whenever the FSM is not in IDLE
//
// Optional feature (macro SNAX_WIDE_SPLIT_SKIP_EN):
//   When defined, banks whose strobe slice is all-zero on a write are marked
//   done at latch time and never see a valid. A write whose strobes are all
//   zero completes without leaving IDLE.
// -----------------------------------------------------------------------------
module snax_wide_req_splitter #(
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned NarrowDataWidth = 32,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned NumBanks        = WideDataWidth / NarrowDataWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 wide_q_valid_i,
  output logic                                 wide_q_ready_o,
  input  logic [AddrWidth-1:0]                 wide_q_addr_i,
  input  logic                                 wide_q_write_i,
  input  logic [WideDataWidth-1:0]             wide_q_data_i,
  input  logic [WideDataWidth/8-1:0]           wide_q_strb_i,
  output logic                                 wide_p_valid_o,
  input  logic                                 wide_p_ready_i,
  output logic [WideDataWidth-1:0]             wide_p_data_o,
  output logic [NumBanks-1:0]                  bank_q_valid_o,
  input  logic [NumBanks-1:0]                  bank_q_ready_i,
  output logic [NumBanks*AddrWidth-1:0]        bank_q_addr_o,
  output logic [NumBanks-1:0]                  bank_q_write_o,
  output logic [NumBanks*NarrowDataWidth-1:0]  bank_q_data_o,
  output logic [NumBanks*NarrowDataWidth/8-1:0] bank_q_strb_o,
  input  logic [NumBanks*NarrowDataWidth-1:0]  bank_p_data_i,
  output logic                                 busy_o
);

  localparam int unsigned NarrowStrbWidth = NarrowDataWidth / 8;
  localparam int unsigned WideStrbWidth   = WideDataWidth / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e                     state_q, state_d;
  logic [AddrWidth-1:0]       addr_q, addr_d;
  logic                       write_q, write_d;
  logic [WideDataWidth-1:0]   data_q, data_d;
  logic [WideStrbWidth-1:0]   strb_q, strb_d;
  logic [NumBanks-1:0]        done_q, done_d;
  logic [NumBanks-1:0]        cap_q, cap_d;
  logic [WideDataWidth-1:0]   buf_q, buf_d;

  logic [NumBanks-1:0]        bank_hs;
  logic [NumBanks-1:0]        skip_mask;

  // Bank-side request outputs: slices of the latched request. Valid is gated
  // to ISSUE, so payloads only change while no valid is asserted.
  always_comb begin
    bank_q_valid_o = (state_q == ISSUE) ? ~done_q : '0;
    bank_q_write_o = {NumBanks{write_q}};
    bank_q_data_o  = data_q;
    bank_q_strb_o  = strb_q;
    bank_q_addr_o  = '0;
    for (int i = 0; i < int'(NumBanks); i++) begin
      bank_q_addr_o[i*AddrWidth +: AddrWidth] = addr_q + AddrWidth'(i * NarrowStrbWidth);
    end
  end

  assign bank_hs        = bank_q_valid_o & bank_q_ready_i;
  assign wide_q_ready_o = (state_q == IDLE);
  assign wide_p_valid_o = (state_q == RESP);
  assign wide_p_data_o  = buf_q;
  assign busy_o         = (state_q != IDLE);

  // Banks that are pre-completed at latch time (zero-strobe writes).
  always_comb begin
    skip_mask = '0;
`ifdef SNAX_WIDE_SPLIT_SKIP_EN
    for (int i = 0; i < int'(NumBanks); i++) begin
      skip_mask[i] = wide_q_write_i &
                     ~(|wide_q_strb_i[i*NarrowStrbWidth +: NarrowStrbWidth]);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    data_d  = data_q;
    strb_d  = strb_q;
    done_d  = done_q | bank_hs;
    // Read data shows up one cycle after each bank's own handshake. Each
    // capture flag lives for exactly that one cycle.
    cap_d   = write_q ? '0 : bank_hs;
    buf_d   = buf_q;

    for (int i = 0; i < int'(NumBanks); i++) begin
      if (cap_q[i]) begin
        buf_d[i*NarrowDataWidth +: NarrowDataWidth] =
          bank_p_data_i[i*NarrowDataWidth +: NarrowDataWidth];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (wide_q_valid_i) begin
          // The low bits are masked so each bank address starts at a wide-aligned base.
          addr_d  = wide_q_addr_i & ~AddrWidth'(WideStrbWidth - 1);
          write_d = wide_q_write_i;
          data_d  = wide_q_data_i;
          strb_d  = wide_q_strb_i;
          done_d  = skip_mask;
          cap_d   = '0;
          state_d = (&skip_mask) ? IDLE : ISSUE;
        end
      end
      ISSUE: begin
        // Count handshakes from this cycle too, so the last bank costs no extra cycle.
        if (&(done_q | bank_hs)) begin
          state_d = write_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        state_d = RESP;
      end
      RESP: begin
        if (wide_p_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      done_q  <= '0;
      cap_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      done_q  <= done_d;
      cap_q   <= cap_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_snax_wide_req_splitter.sv
// -----------------------------------------------------------------------------
// tb_snax_wide_req_splitter
//
// Purpose:
//   Directed testbench for snax_wide_req_splitter in its default configuration
//   (48-bit address, 16 banks of 32 bits). A small bank model returns
//   memVal[i] the cycle after a handshake on bank i. In every other cycle it
//   drives a recognisable junk pattern, so a capture taken in the wrong cycle
//   shows up as bad data.
// -----------------------------------------------------------------------------
module tb_snax_wide_req_splitter;

  localparam int AW = 48;
  localparam int NW = 32;
  localparam int WW = 512;
  localparam int NB = WW / NW;

  logic              clk;
  logic              rst;
  logic              wideQValid;
  logic              wideQReady;
  logic [AW-1:0]     wideQAddr;
  logic              wideQWrite;
  logic [WW-1:0]     wideQData;
  logic [WW/8-1:0]   wideQStrb;
  logic              widePValid;
  logic              widePReady;
  logic [WW-1:0]     widePData;
  logic [NB-1:0]     bankQValid;
  logic [NB-1:0]     bankQReady;
  logic [NB*AW-1:0]  bankQAddr;
  logic [NB-1:0]     bankQWrite;
  logic [NB*NW-1:0]  bankQData;
  logic [NB*NW/8-1:0] bankQStrb;
  logic [NB*NW-1:0]  bankPData;
  logic              busy;

  logic [31:0]       memVal [NB];
  int                errors;
  int                checks;
  logic [WW-1:0]     expData;

  snax_wide_req_splitter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wide_q_valid_i (wideQValid),
    .wide_q_ready_o (wideQReady),
    .wide_q_addr_i  (wideQAddr),
    .wide_q_write_i (wideQWrite),
    .wide_q_data_i  (wideQData),
    .wide_q_strb_i  (wideQStrb),
    .wide_p_valid_o (widePValid),
    .wide_p_ready_i (widePReady),
    .wide_p_data_o  (widePData),
    .bank_q_valid_o (bankQValid),
    .bank_q_ready_i (bankQReady),
    .bank_q_addr_o  (bankQAddr),
    .bank_q_write_o (bankQWrite),
    .bank_q_data_o  (bankQData),
    .bank_q_strb_o  (bankQStrb),
    .bank_p_data_i  (bankPData),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: read data appears only in the cycle after a handshake.
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (bankQValid[i] && bankQReady[i]) begin
        bankPData[i*NW +: NW] <= memVal[i];
      end else begin
        bankPData[i*NW +: NW] <= 32'hDEAD0000 | i;
      end
    end
  end

  // Advance one clock and settle just after the edge; all checks and input
  // changes happen at this point.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [WW-1:0] observed,
                             input logic [WW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [AW-1:0] addr,
                               input logic write, input logic [WW-1:0] data,
                               input logic [WW/8-1:0] strb);
    wideQValid = valid;
    wideQAddr  = addr;
    wideQWrite = write;
    wideQData  = data;
    wideQStrb  = strb;
  endtask

  task automatic loadMem(input logic [31:0] base, input logic [31:0] stride);
    for (int i = 0; i < NB; i++) memVal[i] = base + i * stride;
  endtask

  function automatic logic [WW-1:0] buildWide(input logic [31:0] base,
                                              input logic [31:0] stride);
    logic [WW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*NW +: NW] = base + i * stride;
    return r;
  endfunction

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    widePReady = 1'b0;
    bankQReady = '1;
    bankPData  = '0;
    loadMem(32'h0, 32'h0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    stepCycle();
    stepCycle();

    $display("[TB] reset state");
    checkOutput("rst_q_ready", wideQReady, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_p_valid", widePValid, 0);
    checkOutput("rst_bank_valid", bankQValid, 0);
    checkOutput("rst_p_data", widePData, 0);
    rst = 1'b0;
    stepCycle();

    // ---------------- read, no stalls ----------------
    $display("[TB] basic read");
    loadMem(32'hA0000000, 32'h1);
    applyStimulus(1'b1, 48'h1000, 1'b0, '0, '1);
    stepCycle();                                   // accept edge
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("rd1_bank_valid", bankQValid, 16'hFFFF);
    checkOutput("rd1_addr0", bankQAddr[0 +: AW], 48'h1000);
    checkOutput("rd1_addr5", bankQAddr[5*AW +: AW], 48'h1014);
    checkOutput("rd1_addr15", bankQAddr[15*AW +: AW], 48'h103C);
    checkOutput("rd1_write", bankQWrite, 0);
    checkOutput("rd1_q_ready", wideQReady, 0);
    stepCycle();
    checkOutput("rd1_bank_valid_after", bankQValid, 0);
    checkOutput("rd1_p_valid_c2", widePValid, 0);
    stepCycle();
    checkOutput("rd1_p_valid_c3", widePValid, 1);
    checkOutput("rd1_p_data", widePData, buildWide(32'hA0000000, 32'h1));
    widePReady = 1'b1;
    stepCycle();
    widePReady = 1'b0;
    checkOutput("rd1_p_valid_done", widePValid, 0);
    checkOutput("rd1_q_ready_done", wideQReady, 1);

    // ---------------- write with bank 3 stalled ----------------
    $display("[TB] write with bank 3 stall");
    bankQReady = 16'hFFF7;
    applyStimulus(1'b1, 48'h2000, 1'b1, {64{8'h5A}}, '1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("wr_bank_valid_c1", bankQValid, 16'hFFFF);
    checkOutput("wr_write", bankQWrite, 16'hFFFF);
    checkOutput("wr_data", bankQData, {64{8'h5A}});
    checkOutput("wr_strb", bankQStrb, {64{1'b1}});
    for (int k = 2; k <= 4; k++) begin
      stepCycle();
      checkOutput($sformatf("wr_bank_valid_c%0d", k), bankQValid, 16'h0008);
      checkOutput($sformatf("wr_q_ready_c%0d", k), wideQReady, 0);
      checkOutput($sformatf("wr_data3_c%0d", k), bankQData[3*NW +: NW], 32'h5A5A5A5A);
    end
    bankQReady = '1;
    checkOutput("wr_bank3_valid_held", bankQValid, 16'h0008);
    stepCycle();
    checkOutput("wr_q_ready_back", wideQReady, 1);
    checkOutput("wr_busy_done", busy, 0);
    checkOutput("wr_no_resp", widePValid, 0);
    stepCycle();
    checkOutput("wr_no_resp_later", widePValid, 0);

    // ---------------- read, banks readied in reverse order ----------------
    $display("[TB] reverse-order read");
    loadMem(32'hC0000000, 32'h111);
    bankQReady = '0;
    applyStimulus(1'b1, 48'h207F, 1'b0, '0, '1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("rev_addr0_aligned", bankQAddr[0 +: AW], 48'h2040);
    checkOutput("rev_addr15_aligned", bankQAddr[15*AW +: AW], 48'h207C);
    for (int k = NB - 1; k >= 0; k--) begin
      logic [31:0] pend;
      pend = (32'd1 << (k + 1)) - 32'd1;
      checkOutput($sformatf("rev_valid_k%0d", k), bankQValid, pend[NB-1:0]);
      bankQReady = '0;
      bankQReady[k] = 1'b1;
      stepCycle();
    end
    bankQReady = '1;
    checkOutput("rev_wait_no_valid", widePValid, 0);
    stepCycle();
    checkOutput("rev_p_valid", widePValid, 1);
    checkOutput("rev_p_data", widePData, buildWide(32'hC0000000, 32'h111));
    widePReady = 1'b1;
    stepCycle();
    widePReady = 1'b0;

    // ---------------- response back-pressure ----------------
    $display("[TB] response back-pressure");
    loadMem(32'hB0000000, 32'h1);
    expData = buildWide(32'hB0000000, 32'h1);
    applyStimulus(1'b1, 48'h0, 1'b0, '0, '1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    stepCycle();
    stepCycle();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_p_valid_%0d", k), widePValid, 1);
      checkOutput($sformatf("bp_p_data_%0d", k), widePData, expData);
      checkOutput($sformatf("bp_q_ready_%0d", k), wideQReady, 0);
      // A request offered during RESP must not be taken.
      applyStimulus(1'b1, 48'h4000, 1'b1, '0, '1);
      stepCycle();
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
    end
    widePReady = 1'b1;
    checkOutput("bp_p_valid_last", widePValid, 1);
    stepCycle();
    widePReady = 1'b0;
    checkOutput("bp_p_valid_done", widePValid, 0);
    checkOutput("bp_q_ready_done", wideQReady, 1);
    checkOutput("bp_busy_done", busy, 0);

    // ---------------- reset in ISSUE ----------------
    $display("[TB] reset mid-transaction");
    loadMem(32'hE0000000, 32'h1);
    bankQReady = 16'h00FF;
    applyStimulus(1'b1, 48'h3000, 1'b0, '0, '1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    stepCycle();
    checkOutput("mrst_half_done", bankQValid, 16'hFF00);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("mrst_bank_valid", bankQValid, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_q_ready", wideQReady, 1);
    checkOutput("mrst_p_valid", widePValid, 0);
    bankQReady = '1;
    loadMem(32'hD0000000, 32'h3);
    applyStimulus(1'b1, 48'h3000, 1'b0, '0, '1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("mrst_rd_valid", bankQValid, 16'hFFFF);
    stepCycle();
    stepCycle();
    checkOutput("mrst_rd_p_valid", widePValid, 1);
    checkOutput("mrst_rd_p_data", widePData, buildWide(32'hD0000000, 32'h3));
    widePReady = 1'b1;
    stepCycle();
    widePReady = 1'b0;

    // ---------------- zero-strobe banks ----------------
    $display("[TB] partial-strobe write");
    applyStimulus(1'b1, 48'h5000, 1'b1, {16{32'h12345678}}, 64'h000F);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
`ifdef SNAX_WIDE_SPLIT_SKIP_EN
    checkOutput("skip_bank_valid", bankQValid, 16'h0001);
`else
    checkOutput("skip_bank_valid", bankQValid, 16'hFFFF);
`endif
    checkOutput("skip_strb0", bankQStrb[3:0], 4'hF);
    checkOutput("skip_strb1", bankQStrb[7:4], 4'h0);
    stepCycle();
    checkOutput("skip_q_ready", wideQReady, 1);
    checkOutput("skip_no_resp", widePValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snax_wide_req_splitter.md
Name: snax_wide_req_splitter

Overview:
- Upstream stage of the banked local memory superbank.
- Accepts one wide (WideDataWidth) DMA request, splits it into NumBanks narrow per-bank requests, and issues each with its own valid/ready handshake.
- For reads, collects each bank's pipelined read data, which arrives one cycle after that bank's handshake, and returns one reassembled wide response.
- Absorbs per-bank stalls, such as an atomic shim deasserting ready, so the wide side sees a single transaction.

Parameters:
- AddrWidth, 48, byte address width on both sides.
- NarrowDataWidth, 32, bank data width in bits.
- WideDataWidth, 512, wide data width in bits; must be a multiple of NarrowDataWidth.
- NumBanks, WideDataWidth/NarrowDataWidth, number of bank ports.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- wide_q_valid_i  in  1  wide request valid.
- wide_q_ready_o  out  1  wide request ready.
- wide_q_addr_i  in  AddrWidth  byte address; low log2(WideDataWidth/8) bits ignored (treated as 0).
- wide_q_write_i  in  1  1 = write, 0 = read.
- wide_q_data_i  in  WideDataWidth  write data.
- wide_q_strb_i  in  WideDataWidth/8  byte strobes.
- wide_p_valid_o  out  1  read response valid.
- wide_p_ready_i  in  1  read response ready.
- wide_p_data_o  out  WideDataWidth  read data.
- bank_q_valid_o  out  NumBanks  per-bank request valid.
- bank_q_ready_i  in  NumBanks  per-bank request ready.
- bank_q_addr_o  out  NumBanks*AddrWidth  per-bank address.
- bank_q_write_o  out  NumBanks  per-bank write.
- bank_q_data_o  out  NumBanks*NarrowDataWidth  per-bank write data.
- bank_q_strb_o  out  NumBanks*NarrowDataWidth/8  per-bank strobes.
- bank_p_data_i  in  NumBanks*NarrowDataWidth  per-bank read data; valid the cycle after that bank's handshake.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; done and capture flags cleared; data buffer 0; all bank_q_valid_o = 0; wide_p_valid_o = 0; busy_o = 0; wide_q_ready_o = 1.
- Reset mid-transaction aborts at once and discards partial data. Bank valids may drop without a handshake; this is permitted under reset only.
- Request slicing:
  - Bank i address = aligned wide address + i*(NarrowDataWidth/8).
  - Bank i data and strobe = slice i of the latched request.
  - Bank i write = the latched write bit.
- IDLE:
  - wide_q_ready_o = 1.
  - On wide_q_valid_i, latch addr/write/data/strb, clear the done flags, go to ISSUE.
- ISSUE:
  - bank_q_valid_o[i] = !done[i].
  - On bank_q_valid_o[i] && bank_q_ready_i[i], set done[i]. For reads, also set cap[i].
  - Once set, a bank's valid stays low for the rest of the transaction.
  - Banks complete independently, in any order and in any cycles.
  - bank_q_* payloads stay stable while valid is high.
- Capture: in any cycle where cap[i] is set, register bank_p_data_i slice i into buffer slice i, then clear cap[i].
- Leaving ISSUE once all done bits are set (including bits set in the current cycle):
  - Write: go to IDLE.
  - Read: go to WAIT.
- WAIT:
  - Lasts exactly one cycle, for the final captures.
  - Then go to RESP.
- RESP:
  - wide_p_valid_o = 1; wide_p_data_o = buffer.
  - Data is held stable until wide_p_ready_i, then go to IDLE.
  - No new request is accepted while in RESP.
- Latency with no stalls:
  - Read: wide accept in cycle 0, bank handshakes in cycle 1, capture in cycle 2, wide_p_valid_o in cycle 3.
  - Write: ready again in cycle 2.
- Per-bank stalls extend ISSUE only. Each bank's data is captured exactly one cycle after its own handshake, so an early bank's data is not overwritten while later banks are still pending.
- Exactly one transaction is outstanding at a time.

Optional Feature:
- Macro: SNAX_WIDE_SPLIT_SKIP_EN.
- Defined: on a write, banks whose strobe slice is all-zero are marked done at latch time and never see a valid. If every slice is zero, the FSM returns to IDLE the cycle after accept.
- Undefined: every bank is always issued, including zero-strobe writes.

Test Plan:
- Read, all bank_q_ready_i = 1, addr 0x1000, bank i returns 0xA0000000+i:
  - bank i addr = 0x1000+4i;
  - wide_p_valid_o rises 3 cycles after accept;
  - wide_p_data_o slice i = 0xA0000000+i.
- Write, data all-0x5A, strb all-1, bank 3 ready held low 4 cycles:
  - banks other than 3 handshake in cycle 1;
  - bank 3 valid stays high until ready;
  - wide_q_ready_o returns 1 the cycle after bank 3 completes;
  - no wide response.
- Read with banks readied in reverse order, one per cycle, each returning a distinct value:
  - buffer slices are all correct;
  - no slice is overwritten by a later bank.
- Read response with wide_p_ready_i held low 5 cycles:
  - data stable and valid high throughout;
  - wide_q_ready_o = 0 until the response handshake.
- rst_i asserted in ISSUE with half the banks done:
  - next cycle all valids = 0, busy_o = 0, wide_q_ready_o = 1;
  - the next read completes correctly.
- With SNAX_WIDE_SPLIT_SKIP_EN, write with strb = 0x000F (bank 0 only):
  - only bank_q_valid_o[0] asserts;
  - without the macro, all NumBanks valids assert.
